mc_sequencer: RTL

Multicycle sequencer for the ARM core datapath. It replaces the single-cycle decode path: it walks each instruction through fetch, decode, execute, memory and writeback states, driving datapath selects and write enables one state per cycle. It holds the NZCV flag register and evaluates condition codes. It sits between the instruction/data memory interface and the datapath, gated by the processor `start` input.

---
 rtl/mc_seq_pkg.sv | 74 +++++++
 rtl/mc_sequencer_cond_check.sv | 37 +++
 rtl/mc_sequencer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/mc_seq_pkg.sv
// Shared types and encodings for the multicycle ARM sequencer.
// States, ALU/cmd codes, mux select encodings and condition codes.
package mc_seq_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCB_WD   = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    function automatic logic cmd_known(input logic [3:0] cmd);
        return (cmd == CMD_ADD) || (cmd == CMD_SUB) ||
               (cmd == CMD_AND) || (cmd == CMD_ORR) ||
               (cmd == CMD_CMP);
    endfunction

    function automatic logic [2:0] cmd_alu(input logic [3:0] cmd);
        case (cmd)
            CMD_SUB, CMD_CMP: return ALU_SUB;
            CMD_AND:          return ALU_AND;
            CMD_ORR:          return ALU_ORR;
            default:          return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mc_sequencer_cond_check.sv
// Condition-code evaluator against registered NZCV flags.
// Purely combinational; code 1111 never passes.
module cond_check
    import mc_seq_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic n, z, c, v;

    assign {n, z, c, v} = flags;

    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = ~z;
            COND_CS: pass = c;
            COND_CC: pass = ~c;
            COND_MI: pass = n;
            COND_PL: pass = ~n;
            COND_VS: pass = v;
            COND_VC: pass = ~v;
            COND_HI: pass = c & ~z;
            COND_LS: pass = ~c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = ~z & (n == v);
            COND_LE: pass = z | (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_sequencer.sv
// Multicycle ARM control sequencer with NZCV flags and condition check.
// Define MC_SEQ_PERF_EN to build the retired-instruction and busy-cycle counters.
module mc_sequencer
    import mc_seq_pkg::*;
#(
    parameter int FLAG_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [3:0]        Cond,
    input  logic [1:0]        Op,
    input  logic [5:0]        Funct,
    input  logic [FLAG_W-1:0] ALUFlags,
    output logic              PCWrite,
    output logic              IRWrite,
    output logic              AdrSrc,
    output logic              MemWrite,
    output logic              RegWrite,
    output logic [1:0]        ResultSrc,
    output logic              ALUSrcA,
    output logic [1:0]        ALUSrcB,
    output logic [1:0]        ImmSrc,
    output logic [1:0]        RegSrc,
    output logic [2:0]        ALUControl,
    output logic              busy,
    output logic [31:0]       instr_count,
    output logic [31:0]       cycle_count
);

    state_t            state_q, state_d;
    state_t            next_instr;
    logic [FLAG_W-1:0] flags_q, flags_d;
    logic              cond_q, cond_d;
    logic              cond_pass;
    logic              retire;
    logic [3:0]        cmd;
    logic              is_cmp;
    logic              known;
    logic              writes;
    logic              arith;

    cond_check u_cond_check (
        .cond  (Cond),
        .flags (flags_q[3:0]),
        .pass  (cond_pass)
    );

    assign cmd    = Funct[4:1];
    assign is_cmp = (cmd == CMD_CMP);
    assign known  = cmd_known(cmd);
    assign writes = known & ~is_cmp;
    assign arith  = (cmd == CMD_ADD) | (cmd == CMD_SUB) | is_cmp;

    always_comb begin
        next_instr = start ? S_FETCH : S_IDLE;
        state_d    = state_q;
        flags_d    = flags_q;
        cond_d     = cond_q;
        retire     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                cond_d = cond_pass;
                if (!cond_pass) begin
                    retire  = 1'b1;
                    state_d = next_instr;
                end else begin
                    case (Op)
                        OP_MEM: state_d = S_MEMADR;
                        OP_BR:  state_d = S_BRANCH;
                        OP_DP:  state_d = Funct[5] ? S_EXECI : S_EXECR;
                        default: begin
                            retire  = 1'b1;
                            state_d = next_instr;
                        end
                    endcase
                end
            end
            S_MEMADR: state_d = Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXECR, S_EXECI: begin
                if (writes) begin
                    state_d = S_ALUWB;
                end else begin
                    retire  = 1'b1;
                    state_d = next_instr;
                end
                // CV only follows the ALU for arithmetic ops
                if (known && Funct[0]) begin
                    flags_d[3:2] = ALUFlags[3:2];
                    if (arith) flags_d[1:0] = ALUFlags[1:0];
                end
            end
            S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH: begin
                retire  = 1'b1;
                state_d = next_instr;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            flags_q <= '0;
            cond_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
            cond_q  <= cond_d;
        end
    end

    assign busy = (state_q != S_IDLE);

    always_comb begin
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_WD;
        ALUControl = ALU_ADD;
        ImmSrc     = busy ? Op : 2'b00;
        RegSrc     = 2'b00;
        if (busy) begin
            RegSrc[0] = (Op == OP_BR);
            RegSrc[1] = (Op == OP_MEM) & ~Funct[0];
        end
        case (state_q)
            S_FETCH: begin
                IRWrite   = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALU;
                PCWrite   = 1'b1;
            end
            S_DECODE: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_FOUR;
            end
            S_MEMADR: ALUSrcB = SRCB_IMM;
            S_MEMRD:  AdrSrc  = 1'b1;
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = cond_q;
            end
            S_MEMWR: begin
                AdrSrc   = 1'b1;
                MemWrite = cond_q;
            end
            S_EXECR: ALUControl = cmd_alu(cmd);
            S_EXECI: begin
                ALUSrcB    = SRCB_IMM;
                ALUControl = cmd_alu(cmd);
            end
            S_ALUWB: begin
                ResultSrc = RES_ALUOUT;
                RegWrite  = cond_q & ~is_cmp;
            end
            S_BRANCH: begin
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALU;
                PCWrite   = cond_q;
            end
            default: ;
        endcase
    end

`ifdef MC_SEQ_PERF_EN
    logic [31:0] instr_cnt_q, instr_cnt_d;
    logic [31:0] cyc_cnt_q, cyc_cnt_d;

    always_comb begin
        instr_cnt_d = instr_cnt_q + {31'd0, retire};
        cyc_cnt_d   = cyc_cnt_q + {31'd0, busy};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_cnt_q <= '0;
            cyc_cnt_q   <= '0;
        end else begin
            instr_cnt_q <= instr_cnt_d;
            cyc_cnt_q   <= cyc_cnt_d;
        end
    end

    assign instr_count = instr_cnt_q;
    assign cycle_count = cyc_cnt_q;
`else
    assign instr_count = 32'd0;
    assign cycle_count = 32'd0;
`endif

endmodule
